detector_borda_multi: RTL and testbench



---
 rtl/detector_borda_multi.sv | 123 ++++++++++++
 tb/tb_detector_borda_multi.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_borda_multi.sv
// detector_borda_multi: parametrised multi-channel edge detector.
// Each channel has its own input synchroniser and debounce filter. Qualified
// edges produce one-cycle pulses on detector and set sticky, write-1-to-clear
// bits in flag.
// Optional feature: define DETECTOR_BORDA_COUNT_EN to add a saturating 16-bit
// counter of cycles in which any channel fired (event_count, cleared by cnt_clr).
module detector_borda_multi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] entrada,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] clr,
`ifdef DETECTOR_BORDA_COUNT_EN
    input  logic             cnt_clr,
    output logic [15:0]      event_count,
`endif
    output logic [WIDTH-1:0] detector,
    output logic [WIDTH-1:0] flag,
    output logic             any_event
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } edge_mode_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_v;
    logic [WIDTH-1:0] stable_q;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] det_next;
    edge_mode_t       mode_sel;

    assign sync_v   = sync_q[SYNC_STAGES-1];
    assign mode_sel = edge_mode_t'(mode);

    // Synchroniser chain: bring the asynchronous inputs into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= entrada;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Detect the update event per channel and qualify its edge against mode
    always_comb begin
        update   = '0;
        det_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            update[i] = (sync_v[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
            if (update[i]) begin
                case (mode_sel)
                    MODE_RISE: det_next[i] = sync_v[i];
                    MODE_FALL: det_next[i] = ~sync_v[i];
                    MODE_BOTH: det_next[i] = 1'b1;
                    default:   det_next[i] = 1'b0;
                endcase
            end
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_v[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (update[i]) begin
                    stable_q[i] <= sync_v[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Event pulses and sticky flags; a new event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            detector <= '0;
            flag     <= '0;
        end else begin
            detector <= det_next;
            flag     <= (flag & ~clr) | det_next;
        end
    end

    assign any_event = |detector;

`ifdef DETECTOR_BORDA_COUNT_EN
    // Saturating count of cycles with at least one event; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            event_count <= '0;
        end else if (any_event && (event_count != 16'hFFFF)) begin
            event_count <= event_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_detector_borda_multi.sv
// Self-checking bench for detector_borda_multi (default parameters).
// The reference model keeps a short history of applied inputs and accepts a
// new level once the synchronised samples in a DEB_CYCLES-long window all
// disagree with the accepted level.
module tb_detector_borda_multi;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DEB_CYCLES  = 4;
    localparam int HIST        = SYNC_STAGES + DEB_CYCLES;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] entrada;
    logic [1:0]       mode;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] detector;
    logic [WIDTH-1:0] flag;
    logic             any_event;
`ifdef DETECTOR_BORDA_COUNT_EN
    logic             cnt_clr;
    logic [15:0]      event_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] hist [HIST];
    logic [WIDTH-1:0] m_stable;
    logic [WIDTH-1:0] m_det;
    logic [WIDTH-1:0] m_flag;
    logic [15:0]      m_count;

    detector_borda_multi #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .entrada(entrada),
        .mode(mode),
        .clr(clr),
`ifdef DETECTOR_BORDA_COUNT_EN
        .cnt_clr(cnt_clr),
        .event_count(event_count),
`endif
        .detector(detector),
        .flag(flag),
        .any_event(any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model by one clock edge using the current inputs
    task automatic modelEdge();
        logic [WIDTH-1:0] upd;
        logic [WIDTH-1:0] new_det;
        if (rst) begin
            for (int j = 0; j < HIST; j++) hist[j] = '0;
            m_stable = '0;
            m_det    = '0;
            m_flag   = '0;
            m_count  = '0;
        end else begin
`ifdef DETECTOR_BORDA_COUNT_EN
            if (cnt_clr) m_count = '0;
            else if ((m_det != '0) && (m_count != 16'hFFFF)) m_count = m_count + 16'd1;
`endif
            upd = '1;
            for (int k = 0; k < DEB_CYCLES; k++) upd &= hist[SYNC_STAGES-1+k] ^ m_stable;
            new_det = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (upd[i]) begin
                    if (mode == 2'b10) new_det[i] = 1'b1;
                    else if (mode == 2'b00) new_det[i] = ~m_stable[i];
                    else if (mode == 2'b01) new_det[i] = m_stable[i];
                end
            end
            m_stable = m_stable ^ upd;
            m_flag   = (m_flag & ~clr) | new_det;
            m_det    = new_det;
            for (int j = HIST-1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = entrada;
        end
    endtask

    task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("detector", 16'(detector), 16'(m_det));
        checkValue("flag", 16'(flag), 16'(m_flag));
        checkValue("any_event", 16'(any_event), 16'(|m_det));
`ifdef DETECTOR_BORDA_COUNT_EN
        checkValue("event_count", event_count, m_count);
`endif
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            modelEdge();
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic countPulses(input int n, input int ch, inout int pulses);
        repeat (n) begin
            applyStimulus(1);
            if (detector[ch]) pulses++;
        end
    endtask

    int n;
    int pulses;
    int sweep_exp [4] = '{1, 1, 2, 0};

    initial begin
        rst     = 1'b1;
        entrada = '0;
        mode    = 2'b00;
        clr     = '0;
`ifdef DETECTOR_BORDA_COUNT_EN
        cnt_clr = 1'b0;
`endif
        for (int j = 0; j < HIST; j++) hist[j] = '0;
        m_stable = '0; m_det = '0; m_flag = '0; m_count = '0;

        // Reset state
        applyStimulus(3);
        checkValue("reset_detector", 16'(detector), 16'h0000);
        checkValue("reset_flag", 16'(flag), 16'h0000);
        checkValue("reset_any", 16'(any_event), 16'h0000);

        // First rising event after release, six edges later
        rst        = 1'b0;
        entrada[0] = 1'b1;
        n = 0;
        while (detector == '0 && n < 20) begin
            applyStimulus(1);
            n++;
        end
        checkValue("latency", 16'(n), 16'd6);
        checkValue("first_pulse", 16'(detector), 16'h0001);
        applyStimulus(1);
        checkValue("pulse_width", 16'(detector), 16'h0000);

        // Mode sweep on channel 3
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            clr  = '1;
            applyStimulus(1);
            clr  = '0;
            pulses = 0;
            entrada[3] = 1'b1;
            countPulses(20, 3, pulses);
            entrada[3] = 1'b0;
            countPulses(20, 3, pulses);
            checkValue("mode_sweep", 16'(pulses), 16'(sweep_exp[m]));
            if (m == 3) checkValue("mode_none_flag", 16'(flag[3]), 16'h0000);
        end

        // Debounce on channel 5
        mode = 2'b00;
        pulses = 0;
        entrada[5] = 1'b1;
        countPulses(3, 5, pulses);
        entrada[5] = 1'b0;
        countPulses(15, 5, pulses);
        checkValue("glitch_3", 16'(pulses), 16'd0);
        pulses = 0;
        entrada[5] = 1'b1;
        countPulses(4, 5, pulses);
        entrada[5] = 1'b0;
        countPulses(15, 5, pulses);
        checkValue("pulse_4", 16'(pulses), 16'd1);
        mode = 2'b10;
        entrada[5] = 1'b1;
        applyStimulus(15);
        pulses = 0;
        entrada[5] = 1'b0;
        countPulses(3, 5, pulses);
        entrada[5] = 1'b1;
        countPulses(15, 5, pulses);
        checkValue("dip_3", 16'(pulses), 16'd0);
        entrada[5] = 1'b0;
        applyStimulus(15);

        // Flag write-1-to-clear on channel 2
        mode = 2'b00;
        clr  = '1;
        applyStimulus(1);
        clr  = '0;
        entrada[2] = 1'b1;
        n = 0;
        while (detector[2] == 1'b0 && n < 20) begin
            applyStimulus(1);
            n++;
        end
        checkValue("w1c_latency", 16'(n), 16'd6);
        checkValue("w1c_flag_set", 16'(flag), 16'h0004);
        clr = 8'h04;
        applyStimulus(1);
        checkValue("w1c_flag_clear", 16'(flag), 16'h0000);
        clr  = '0;
        mode = 2'b01;
        entrada[2] = 1'b0;
        applyStimulus(5);
        clr = 8'h04;
        applyStimulus(1);
        checkValue("w1c_coincident_det", 16'(detector), 16'h0004);
        checkValue("w1c_set_wins", 16'(flag), 16'h0004);
        clr = '0;

        // All channels at once, then a reset just before the expected pulse
        mode    = 2'b00;
        entrada = '0;
        applyStimulus(10);
        entrada = '1;
        applyStimulus(6);
        checkValue("multi_det", 16'(detector), 16'h00FF);
        checkValue("multi_any", 16'(any_event), 16'h0001);
        applyStimulus(1);
        checkValue("multi_once", 16'(detector), 16'h0000);
        entrada = '0;
        applyStimulus(10);
        clr = '1;
        applyStimulus(1);
        clr = '0;
        entrada = '1;
        applyStimulus(4);
        rst = 1'b1;
        applyStimulus(2);
        rst = 1'b0;
        checkValue("midreset_det", 16'(detector), 16'h0000);
        checkValue("midreset_flag", 16'(flag), 16'h0000);
        applyStimulus(10);

`ifdef DETECTOR_BORDA_COUNT_EN
        // Saturating event counter
        entrada = '0;
        applyStimulus(10);
        cnt_clr = 1'b1;
        applyStimulus(1);
        cnt_clr = 1'b0;
        entrada = 8'h01; applyStimulus(10);
        entrada = 8'h03; applyStimulus(10);
        entrada = 8'h07; applyStimulus(10);
        entrada = 8'h00; applyStimulus(10);
        entrada = 8'hFF; applyStimulus(10);
        checkValue("count_four", event_count, 16'd4);
        force dut.event_count = 16'hFFFF;
        #1;
        release dut.event_count;
        m_count = 16'hFFFF;
        entrada = 8'h00; applyStimulus(10);
        entrada = 8'h01; applyStimulus(10);
        entrada = 8'h03; applyStimulus(10);
        checkValue("count_saturate", event_count, 16'hFFFF);
        entrada = 8'h07;
        applyStimulus(6);
        cnt_clr = 1'b1;
        applyStimulus(1);
        cnt_clr = 1'b0;
        checkValue("count_clear_wins", event_count, 16'h0000);
        applyStimulus(5);
`endif

        // Randomised traffic against the reference model
        for (int it = 0; it < 150; it++) begin
            int hold;
            hold    = $urandom_range(1, 8);
            entrada = entrada ^ WIDTH'($urandom);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            clr     = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
            rst     = ($urandom_range(0, 39) == 0);
`ifdef DETECTOR_BORDA_COUNT_EN
            cnt_clr = ($urandom_range(0, 19) == 0);
`endif
            applyStimulus(hold);
        end
        rst = 1'b0;
        clr = '0;
        applyStimulus(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
